// File: rtl/calc_pkg.sv
// Shared constants for the UART calculator: ALU op encoding and the
// largest magnitude the four-digit display can show.
package calc_pkg;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;

  localparam int DEC_MAX = 9999;

endpackage

// File: rtl/tick_gen.sv
// Modulo-DIV counter that raises a one-cycle clock enable in the last
// count of every period; the enable clears as soon as reset asserts.
module tick_gen #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  // Decoded straight from the counter register so the pulse coincides with count == DIV-1.
  assign tick = (count == LAST);

endmodule

// File: rtl/calc_arith_timing.sv
// Arithmetic and timing core of the UART calculator: registered signed ALU
// with decimal range flag, plus baud and display-refresh clock enables.
module calc_arith_timing
  import calc_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int REFRESH_LOG2 = 19
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         op,
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [15:0] result,
  output logic               overflow,
  output logic               baud_tick,
  output logic               baud_clk,
  output logic               refresh_tick
);

  localparam int BAUD_DIV = CLK_HZ / (BAUD * OVERSAMPLE);

  logic signed [31:0] a_ext;
  logic signed [31:0] b_ext;
  logic signed [31:0] p;
  logic               arith_op;
  logic               div_zero;
  logic               out_of_range;

  assign a_ext = 32'(a);
  assign b_ext = 32'(b);

  always_comb begin
    p        = '0;
    arith_op = 1'b0;
    div_zero = 1'b0;
    case (op)
      OP_ADD: begin
        p        = a_ext + b_ext;
        arith_op = 1'b1;
      end
      OP_SUB: begin
        p        = a_ext - b_ext;
        arith_op = 1'b1;
      end
      OP_MUL: begin
        p        = a_ext * b_ext;
        arith_op = 1'b1;
      end
      OP_DIV: begin
        if (b == '0) begin
          div_zero = 1'b1;
        end else begin
          p        = a_ext / b_ext;
          arith_op = 1'b1;
        end
      end
      default: begin
        p = '0;
      end
    endcase
  end

  // Range is judged on the full 32-bit value; the result keeps only the wrapped low half.
  assign out_of_range = (p > DEC_MAX) || (p < -DEC_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      result   <= p[15:0];
      overflow <= div_zero | (arith_op & out_of_range);
    end
  end

  tick_gen #(.DIV(BAUD_DIV)) u_baud_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (baud_tick)
  );

  tick_gen #(.DIV(2 ** REFRESH_LOG2)) u_refresh_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (refresh_tick)
  );

  // Legacy square wave, flips on the edge that closes each baud_tick cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_clk <= 1'b0;
    end else if (baud_tick) begin
      baud_clk <= ~baud_clk;
    end
  end

endmodule

// File: tb/tb_calc_arith_timing.sv
// Randomized bench for calc_arith_timing: ALU results against an integer
// reference, tick timing against cycle-count arithmetic, plus directed cases.
module tb_calc_arith_timing;

  localparam int BAUD_PERIOD    = 651;
  localparam int REFRESH_PERIOD = 16;

  logic               clk;
  logic               reset_n;
  logic [2:0]         op;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic signed [15:0] result;
  logic               overflow;
  logic               baud_tick;
  logic               baud_clk;
  logic               refresh_tick;

  int checks = 0;
  int errors = 0;

  calc_arith_timing #(.REFRESH_LOG2(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op           (op),
    .a            (a),
    .b            (b),
    .result       (result),
    .overflow     (overflow),
    .baud_tick    (baud_tick),
    .baud_clk     (baud_clk),
    .refresh_tick (refresh_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input int x, input int y);
    op = o;
    a  = 16'(x);
    b  = 16'(y);
  endtask

  // Plain-integer view of the ALU: exact value, then the low 16 bits reinterpreted as signed.
  function automatic void ref_alu(input int o, input int x, input int y,
                                 output int r, output int ov);
    longint             p;
    logic signed [15:0] lo;
    r  = 0;
    ov = 0;
    if (o < 1 || o > 4) return;
    if (o == 4 && y == 0) begin
      ov = 1;
      return;
    end
    case (o)
      1:       p = longint'(x) + y;
      2:       p = longint'(x) - y;
      3:       p = longint'(x) * y;
      default: p = longint'(x / y);
    endcase
    lo = p[15:0];
    r  = int'(lo);
    ov = (p > 9999 || p < -9999) ? 1 : 0;
  endfunction

  function automatic int rand_operand();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 19998)) - 9999;
  endfunction

  // Called at a negedge with cycle 1 being the cycle right after reset release.
  task automatic run_cycles(input int n);
    int cyc = 1;
    bit have_prev = 0;
    int exp_r = 0;
    int exp_o = 0;
    for (int i = 0; i < n; i++) begin
      int o, x, y;
      if (have_prev) begin
        checkOutput("alu_result", int'(result), exp_r);
        checkOutput("alu_overflow", int'(overflow), exp_o);
      end
      checkOutput("baud_tick", int'(baud_tick), (cyc % BAUD_PERIOD == 0) ? 1 : 0);
      checkOutput("baud_clk", int'(baud_clk), ((cyc - 1) / BAUD_PERIOD) % 2);
      checkOutput("refresh_tick", int'(refresh_tick), (cyc % REFRESH_PERIOD == 0) ? 1 : 0);
      o = int'($urandom_range(0, 7));
      x = rand_operand();
      y = ($urandom_range(0, 9) == 0) ? 0 : rand_operand();
      applyStimulus(3'(o), x, y);
      ref_alu(o, x, y, exp_r, exp_o);
      have_prev = 1;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic directed(input int o, input int x, input int y, input int want_r, input int want_o);
    int r, ov;
    ref_alu(o, x, y, r, ov);
    applyStimulus(3'(o), x, y);
    @(posedge clk);
    @(negedge clk);
    checkOutput("dir_result", int'(result), want_r);
    checkOutput("dir_overflow", int'(overflow), want_o);
    checkOutput("dir_model", r, want_r);
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(3'd0, 0, 0);
    #2;
    checkOutput("rst_result", int'(result), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    checkOutput("rst_baud_tick", int'(baud_tick), 0);
    checkOutput("rst_baud_clk", int'(baud_clk), 0);
    checkOutput("rst_refresh_tick", int'(refresh_tick), 0);

    @(negedge clk);
    reset_n = 1'b1;
    run_cycles(3 * BAUD_PERIOD + 20);

    // Reset between edges with a nonzero result and a running count.
    applyStimulus(3'd1, 5, 5);
    @(posedge clk);
    @(negedge clk);
    checkOutput("pre_rst_result", int'(result), 10);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("async_result", int'(result), 0);
    checkOutput("async_overflow", int'(overflow), 0);
    checkOutput("async_baud_tick", int'(baud_tick), 0);
    checkOutput("async_baud_clk", int'(baud_clk), 0);
    checkOutput("async_refresh_tick", int'(refresh_tick), 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_cycles(BAUD_PERIOD + 40);

    directed(1, 1234, -34, 1200, 0);
    directed(2, 5000, 6000, -1000, 0);
    directed(3, 100, 100, 10000, 1);
    directed(3, -99, 99, -9801, 0);
    directed(4, -7, 2, -3, 0);
    directed(4, 42, 0, 0, 1);
    directed(0, 123, 456, 0, 0);
    directed(6, -5000, 77, 0, 0);
    directed(1, 9999, 0, 9999, 0);
    directed(2, -9999, 1, -10000, 1);
    directed(3, 300, 300, 24464, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
